// File: rtl/timer_slot_arbiter.sv
// Round-robin owner of one shared elapsed-cycle counter: grants a requester,
// counts its latched (clamped) duration, then pulses a one-hot done back.
module timer_slot_arbiter #(
  parameter int N_REQ     = 4,
  parameter int CNT_WIDTH = 32,
  parameter int MAX_COUNT = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*CNT_WIDTH-1:0] duration,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic                       busy,
  output logic [CNT_WIDTH-1:0]       count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_WIDTH-1:0] MAX_C  = CNT_WIDTH'(MAX_COUNT);
  localparam logic [PTR_W-1:0]     LAST_I = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]       N_C    = (PTR_W + 1)'(N_REQ);
  localparam logic [N_REQ-1:0]     ONE_H  = {{(N_REQ - 1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       owner_q;
  logic [CNT_WIDTH-1:0]   target_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [N_REQ-1:0]       grant_q;
  logic [N_REQ-1:0]       done_q;
  logic                   busy_q;

  logic [N_REQ-1:0]       elig;
  logic [PTR_W:0]         arb_sum;
  logic                   arb_found;
  logic [PTR_W-1:0]       arb_idx;
  logic [CNT_WIDTH-1:0]   dur_sel;
  logic [CNT_WIDTH-1:0]   target_new;
  logic [PTR_W-1:0]       ptr_next;

  // The requester just served is masked only during its done cycle.
  always_comb begin
    elig      = req & ~done_q;
    arb_sum   = '0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_sum   = {1'b0, ptr_q} + (PTR_W + 1)'(k);
      arb_sum   = (arb_sum >= N_C) ? (arb_sum - N_C) : arb_sum;
      arb_idx   = (!arb_found && elig[arb_sum[PTR_W-1:0]]) ? arb_sum[PTR_W-1:0] : arb_idx;
      arb_found = arb_found | elig[arb_sum[PTR_W-1:0]];
    end
  end

  assign dur_sel    = duration[int'(arb_idx)*CNT_WIDTH +: CNT_WIDTH];
  assign target_new = (dur_sel > MAX_C) ? MAX_C : dur_sel;
  assign ptr_next   = (owner_q == LAST_I) ? '0 : (owner_q + PTR_W'(1));

  // Arbitration and counting FSM; abort is checked before completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      target_q <= '0;
      count_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q  <= '0;
          count_q <= '0;
          if (arb_found) begin
            state_q  <= S_RUN;
            owner_q  <= arb_idx;
            grant_q  <= ONE_H << arb_idx;
            busy_q   <= 1'b1;
            target_q <= target_new;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!req[owner_q]) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            done_q  <= '0;
            ptr_q   <= ptr_next;
          end else if (count_q == target_q) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            done_q  <= grant_q;
            ptr_q   <= ptr_next;
          end else begin
            count_q <= count_q + CNT_WIDTH'(1);
            done_q  <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
          done_q  <= '0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: doc/timer_slot_arbiter.md
Name: timer_slot_arbiter

Overview:
- Shares one elapsed-cycle counter between N_REQ requesters that each need a timed interval (timeouts, settle delays).
- Round-robin arbiter grants the counter to one requester at a time and latches that requester's duration.
- Counts the interval, then pulses a one-hot done back to the owner.
- Sits between control FSMs and the shared timing resource; replaces per-FSM private counters.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- CNT_WIDTH, 32, width of counter, durations and count output.
- MAX_COUNT, 1000, maximum honoured duration; larger requests clamp to this value.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  N_REQ  level request per requester; held high until done or abort.
- duration  in  N_REQ*CNT_WIDTH  per-requester duration D; slice i = bits [i*CNT_WIDTH +: CNT_WIDTH].
- grant  out  N_REQ  one-hot owner of the counter; all-zero when idle.
- done  out  N_REQ  one-hot, single-cycle completion pulse.
- busy  out  1  high while any grant is high.
- count  out  CNT_WIDTH  elapsed cycles of the current grant.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: grant=0, done=0, busy=0, count=0, target=0, state=IDLE, rr pointer=0. Reset mid-RUN aborts silently: no done pulse.
- All outputs are registered.
- States: IDLE, RUN.
- IDLE arbitration:
  - Scan req starting at the rr pointer, wrapping modulo N_REQ; the first set bit i wins.
  - On the next edge: state=RUN, grant=onehot(i), busy=1, count=0, target=min(duration[i], MAX_COUNT).
  - Arbitration latency is 1 cycle from req visible in IDLE to grant.
- RUN:
  - Each cycle: if count==target, next edge goes to IDLE with grant=0, busy=0, count=0, done=onehot(i) for exactly one cycle, pointer=(i+1) mod N_REQ.
  - Otherwise count increments by 1.
  - Grant therefore stays high for D+1 cycles (counting cycles g..g+D); done is high in cycle g+D+1.
  - D=0 gives a 1-cycle grant.
- Target is latched at grant; duration changes during RUN are ignored.
- Clamp: D>MAX_COUNT behaves exactly as D=MAX_COUNT.
- count never exceeds MAX_COUNT and never wraps.
- Abort: if req[i] is low in any RUN cycle, the next edge goes to IDLE with grant=0, count=0, no done, pointer=(i+1) mod N_REQ.
- Abort takes precedence over completion in the same cycle.
- Done-cycle arbitration:
  - The IDLE cycle in which done is high may arbitrate, but the just-served index is masked for that cycle only.
  - Requesters must drop req on seeing done; if they do not, they are re-eligible from the following cycle.
  - Back-to-back grants are separated by exactly one grant-free cycle.
- Only one grant bit and one done bit may be set at a time, and never in the same cycle.
- Simultaneous requests resolve by round-robin order only; no starvation. Each waiting requester is granted within N_REQ-1 intervening grants.

Test Plan:
- Reset with req=4'b1111 held high → grant=0, done=0, count=0 through the reset cycle; first grant=4'b0001 one cycle after reset deassert.
- req[2]=1, duration[2]=5 → grant=4'b0100 for 6 cycles, count 0..5, done=4'b0100 one cycle after, busy low.
- All four request with D=2, each dropping req on its done → grants 0,1,2,3 in order; each grant 3 cycles; 1 idle cycle between grants; no done overlaps a grant.
- duration[1]=5000, MAX_COUNT=1000 → grant lasts 1001 cycles; count peaks at 1000; a single done.
- req[3] dropped at count=3 with D=10 → grant=0 next cycle, no done pulse, pointer moves to 0 (req[0] granted next).
- rst asserted at count=4 of D=8 → all outputs 0 next edge, no done; D changed mid-run on a fresh grant → original D still honoured.
